// File: rtl/pp_pkg.sv
// Shared types and default constants for the ray/triangle preprocess block.
package pp_pkg;

    localparam int LANES_DEF   = 3;
    localparam int FW_DEF      = 32;
    localparam int TAG_W_DEF   = 16;
    localparam int ADD_LAT_DEF = 3;
    localparam int DEPTH_DEF   = 8;

    // One packed vector of LANES_DEF floats; lane i sits at [i*FW_DEF +: FW_DEF].
    typedef logic [LANES_DEF*FW_DEF-1:0] vec_t;

    // Triangle id travelling alongside the data.
    typedef logic [TAG_W_DEF-1:0] tag_t;

endpackage

// File: rtl/float_add.sv
// IEEE-754 single-precision adder/subtractor with LAT cycles of latency.
// opSel=0 computes a-b, opSel=1 computes a+b; round to nearest even,
// subnormals supported, NaN results are the canonical quiet NaN.
module Float_Add #(
    parameter int LAT = 3
) (
    input  logic        clk,
    input  logic        areset,
    input  logic        en,
    input  logic        opSel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] q
);

    logic [31:0] w_res;
    logic [31:0] r_pipe [LAT];

    function automatic logic [4:0] lzc27(input logic [26:0] x);
        logic [4:0] n;
        n = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (x[i]) n = 5'(26 - i);
        end
        return n;
    endfunction

    // Single-cycle add/subtract core: align, add, normalise, round.
    always_comb begin
        logic        sb, sl, ss, same, rnd;
        logic        a_nan, b_nan, a_inf, b_inf;
        logic [9:0]  el, es, ex, dd;
        logic [23:0] ml, ms;
        logic [26:0] sh, mask, norm;
        logic [27:0] sum;
        logic [4:0]  lz;
        logic [24:0] mr;
        // NOTE: every variable gets a value before any branch so no latch is inferred.
        w_res = '0;
        sb    = b[31] ^ ~opSel;
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != '0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != '0);
        a_inf = (a[30:23] == 8'hFF) && (a[22:0] == '0);
        b_inf = (b[30:23] == 8'hFF) && (b[22:0] == '0);
        // NOTE: blocking '=' here because each step consumes the previous step's value in the same evaluation.
        if (a[30:0] >= b[30:0]) begin
            sl = a[31];
            el = {2'b00, (a[30:23] == '0) ? 8'd1 : a[30:23]};
            ml = {|a[30:23], a[22:0]};
            ss = sb;
            es = {2'b00, (b[30:23] == '0) ? 8'd1 : b[30:23]};
            ms = {|b[30:23], b[22:0]};
        end else begin
            sl = sb;
            el = {2'b00, (b[30:23] == '0) ? 8'd1 : b[30:23]};
            ml = {|b[30:23], b[22:0]};
            ss = a[31];
            es = {2'b00, (a[30:23] == '0) ? 8'd1 : a[30:23]};
            ms = {|a[30:23], a[22:0]};
        end
        same = (sl == ss);
        dd   = el - es;
        // Align the smaller operand; shifted-out bits collapse into the sticky LSB.
        mask = '0;
        if (dd >= 10'd27) begin
            sh = {26'b0, |ms};
        end else begin
            mask  = (27'd1 << dd[4:0]) - 27'd1;
            sh    = {ms, 3'b000} >> dd[4:0];
            sh[0] = sh[0] | (|({ms, 3'b000} & mask));
        end
        sum = same ? ({1'b0, ml, 3'b000} + {1'b0, sh})
                   : ({1'b0, ml, 3'b000} - {1'b0, sh});
        ex   = el;
        lz   = '0;
        norm = sum[26:0];
        if (sum[27]) begin
            norm = {sum[27:2], sum[1] | sum[0]};
            ex   = el + 10'd1;
        end else begin
            lz = lzc27(sum[26:0]);
            // Never normalise below the minimum exponent; that yields a subnormal.
            if ({5'b0, lz} > el - 10'd1) lz = 5'(el - 10'd1);
            norm = sum[26:0] << lz;
            ex   = el - {5'b0, lz};
        end
        rnd = norm[2] & (norm[1] | norm[0] | norm[3]);
        mr  = {1'b0, norm[26:3]} + {24'b0, rnd};
        if (mr[24]) begin
            mr = {1'b0, mr[24:1]};
            ex = ex + 10'd1;
        end
        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != sb))) begin
            w_res = 32'h7FC0_0000;
        end else if (a_inf) begin
            w_res = a;
        end else if (b_inf) begin
            w_res = {sb, b[30:0]};
        end else if (sum == '0) begin
            w_res = {same & sl, 31'b0};
        end else if (ex >= 10'd255) begin
            w_res = {sl, 8'hFF, 23'b0};
        end else begin
            w_res = {sl, mr[23] ? ex[7:0] : 8'h00, mr[22:0]};
        end
    end

    // Latency delay line; advances only while en is high.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            for (int k = 0; k < LAT; k++) r_pipe[k] <= '0;
        end else if (en) begin
            r_pipe[0] <= w_res;
            for (int k = 1; k < LAT; k++) r_pipe[k] <= r_pipe[k-1];
        end
    end

    assign q = r_pipe[LAT-1];

endmodule

// File: rtl/pp_fifo.sv
// Parametrised synchronous FIFO with combinational read data at the head.
// Pointers wrap modulo DEPTH, so non-power-of-two depths work as well.
module pp_fifo
    import pp_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_wr_en,
    input  logic [W-1:0] i_wr_data,
    input  logic         i_rd_en,
    output logic [W-1:0] o_rd_data,
    output logic         o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          w_full;
    logic          w_wr;
    logic          w_rd;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign w_full    = (r_level == FULL_LVL);
    assign o_empty   = (r_level == '0);
    assign w_rd      = i_rd_en && !o_empty;
    // A write into a full FIFO is only legal together with a read of the head.
    assign w_wr      = i_wr_en && (!w_full || w_rd);
    assign o_rd_data = r_mem[r_rd_ptr];

    // Storage write port.
    // NOTE: the memory array has no reset; pointers and level define which entries are live.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointer and occupancy tracking; clear behaves like reset.
    always_ff @(posedge clk) begin
        if (!rst || i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_rd) r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/preprocess_v3.sv
// Ray/triangle preprocess: computes v1-v0, v2-v0 and orig-v0 per lane with
// pipelined float subtractors, then queues results in a credited FIFO so the
// adders never need to stall.
module preprocess_v3
    import pp_pkg::*;
#(
    parameter int LANES   = LANES_DEF,
    parameter int FW      = FW_DEF,
    parameter int ADD_LAT = ADD_LAT_DEF,
    parameter int TAG_W   = TAG_W_DEF,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*FW-1:0]        v0,
    input  logic [LANES*FW-1:0]        v1,
    input  logic [LANES*FW-1:0]        v2,
    input  logic [LANES*FW-1:0]        orig,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*FW-1:0]        v0v1,
    output logic [LANES*FW-1:0]        v0v2,
    output logic [LANES*FW-1:0]        tvec,
    output logic [TAG_W-1:0]           out_tag,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int VW     = LANES * FW;
    localparam int CW     = $clog2(DEPTH + 1);
    localparam int WORD_W = 3 * VW + TAG_W;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic              w_accept;
    logic              w_pop;
    logic              w_empty;
    logic [VW-1:0]     w_d01;
    logic [VW-1:0]     w_d02;
    logic [VW-1:0]     w_dt;
    logic [WORD_W-1:0] w_wr_data;
    logic [WORD_W-1:0] w_rd_data;
    logic [ADD_LAT-1:0] r_vld;
    logic [TAG_W-1:0]  r_tag [ADD_LAT];
    logic [CW-1:0]     r_count;

    // Credit check: count covers both in-flight and queued beats, so an
    // accepted beat always has a FIFO slot waiting when it leaves the adders.
    assign in_ready  = (r_count < DEPTH_C) && !flush;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = !w_empty;
    assign w_pop     = out_valid && out_ready;
    assign count     = r_count;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        Float_Add #(.LAT(ADD_LAT)) u_sub_v1 (
            .clk    (clk),
            .areset (1'b0),
            .en     (1'b1),
            .opSel  (1'b0),
            .a      (v1[i*FW +: FW]),
            .b      (v0[i*FW +: FW]),
            .q      (w_d01[i*FW +: FW])
        );
        Float_Add #(.LAT(ADD_LAT)) u_sub_v2 (
            .clk    (clk),
            .areset (1'b0),
            .en     (1'b1),
            .opSel  (1'b0),
            .a      (v2[i*FW +: FW]),
            .b      (v0[i*FW +: FW]),
            .q      (w_d02[i*FW +: FW])
        );
        Float_Add #(.LAT(ADD_LAT)) u_sub_or (
            .clk    (clk),
            .areset (1'b0),
            .en     (1'b1),
            .opSel  (1'b0),
            .a      (orig[i*FW +: FW]),
            .b      (v0[i*FW +: FW]),
            .q      (w_dt[i*FW +: FW])
        );
    end

    // Valid tracking in lockstep with the adders; flush and reset kill all in-flight beats.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= w_accept;
            for (int k = 1; k < ADD_LAT; k++) r_vld[k] <= r_vld[k-1];
        end
    end

    // Tag delay line; contents only matter where the matching r_vld bit is set.
    always_ff @(posedge clk) begin
        r_tag[0] <= in_tag;
        for (int k = 1; k < ADD_LAT; k++) r_tag[k] <= r_tag[k-1];
    end

    // Credit counter: +1 on accept, -1 on output handshake, unchanged when both.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            r_count <= '0;
        end else if (w_accept && !w_pop) begin
            r_count <= r_count + 1'b1;
        end else if (!w_accept && w_pop) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign w_wr_data = {w_d01, w_d02, w_dt, r_tag[ADD_LAT-1]};

    pp_fifo #(
        .W     (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (flush),
        .i_wr_en   (r_vld[ADD_LAT-1]),
        .i_wr_data (w_wr_data),
        .i_rd_en   (out_ready),
        .o_rd_data (w_rd_data),
        .o_empty   (w_empty)
    );

    assign {v0v1, v0v2, tvec, out_tag} = w_rd_data;

endmodule

// File: tb/tb_preprocess_v3.sv
// Directed and random checks for preprocess_v3 at default parameters.
module tb_preprocess_v3;
    import pp_pkg::*;

    localparam int ADD_LAT = 3;
    localparam int DEPTH   = 8;
    localparam int CW      = $clog2(DEPTH + 1);
    localparam int N_RND   = 1000;

    typedef struct packed {
        vec_t d01;
        vec_t d02;
        vec_t dt;
        tag_t tag;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    vec_t          v0, v1, v2, orig;
    tag_t          in_tag;
    logic          out_valid;
    logic          out_ready;
    vec_t          v0v1, v0v2, tvec;
    tag_t          out_tag;
    logic [CW-1:0] count;

    int n_checks;
    int n_fail;

    // Hand-computed vectors from the single-beat scenario; lane 0 in the low bits.
    localparam vec_t STD_V0   = {32'h4040_0000, 32'h4000_0000, 32'h3F80_0000};
    localparam vec_t STD_V1   = {32'h4100_0000, 32'h40C0_0000, 32'h4080_0000};
    localparam vec_t STD_V2   = {32'h4080_0000, 32'h4000_0000, 32'h3F80_0000};
    localparam vec_t STD_OR   = '0;
    localparam vec_t STD_D01  = {32'h40A0_0000, 32'h4080_0000, 32'h4040_0000};
    localparam vec_t STD_D02  = {32'h3F80_0000, 32'h0000_0000, 32'h0000_0000};
    localparam vec_t STD_DT   = {32'hC040_0000, 32'hC000_0000, 32'hBF80_0000};

    preprocess_v3 #(
        .LANES   (3),
        .FW      (32),
        .ADD_LAT (ADD_LAT),
        .TAG_W   (16),
        .DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .v0        (v0),
        .v1        (v1),
        .v2        (v2),
        .orig      (orig),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .v0v1      (v0v1),
        .v0v2      (v0v2),
        .tvec      (tvec),
        .out_tag   (out_tag),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Exact integer-to-single conversion for |x| < 2^24.
    function automatic logic [31:0] int2fp(input int x);
        int          m;
        int          p;
        logic [31:0] r;
        if (x == 0) return 32'h0;
        m = (x < 0) ? -x : x;
        p = 0;
        for (int i = 0; i < 24; i++) if (m[i]) p = i;
        r[31]    = (x < 0);
        r[30:23] = 8'(127 + p);
        r[22:0]  = 23'((m << (23 - p)) & 32'h007F_FFFF);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_std(input tag_t t);
        v0     = STD_V0;
        v1     = STD_V1;
        v2     = STD_V2;
        orig   = STD_OR;
        in_tag = t;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drive_std(16'h0);
        tick();
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        n_checks++;
        if (count !== '0) begin
            n_fail++; $display("FAIL reset_count: got %0d want 0", count);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        tick();
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        drive_std(16'h0005);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int cyc = 1; cyc <= ADD_LAT + 1; cyc++) begin
            n_checks++;
            if (out_valid !== (cyc == ADD_LAT + 1)) begin
                n_fail++; $display("FAIL single_latency: cycle %0d out_valid=%b", cyc, out_valid);
            end
            if (cyc == ADD_LAT + 1) begin
                n_checks++;
                if (v0v1 !== STD_D01) begin
                    n_fail++; $display("FAIL single_v0v1: got %h want %h", v0v1, STD_D01);
                end
                n_checks++;
                if (v0v2 !== STD_D02) begin
                    n_fail++; $display("FAIL single_v0v2: got %h want %h", v0v2, STD_D02);
                end
                n_checks++;
                if (tvec !== STD_DT) begin
                    n_fail++; $display("FAIL single_tvec: got %h want %h", tvec, STD_DT);
                end
                n_checks++;
                if (out_tag !== 16'h0005) begin
                    n_fail++; $display("FAIL single_tag: got %h want 0005", out_tag);
                end
            end
            tick();
        end
        n_checks++;
        if (out_valid !== 1'b0 || count !== '0) begin
            n_fail++; $display("FAIL single_drain: out_valid=%b count=%0d want 0/0", out_valid, count);
        end
    endtask

    task automatic test_back_to_back();
        int sent;
        int got;
        int first_cyc;
        sent = 0; got = 0; first_cyc = -1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && got < 20; cyc++) begin
            if (out_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                n_checks++;
                if (out_tag !== tag_t'(got) || cyc != first_cyc + got) begin
                    n_fail++;
                    $display("FAIL b2b_order: cycle %0d tag %0d want tag %0d at cycle %0d",
                             cyc, out_tag, got, first_cyc + got);
                end
                got++;
            end
            n_checks++;
            if (count > CW'(ADD_LAT + 1)) begin
                n_fail++; $display("FAIL b2b_count: got %0d want <= %0d", count, ADD_LAT + 1);
            end
            drive_std(tag_t'(sent));
            in_valid = (sent < 20);
            #1;
            if (in_valid && in_ready) sent++;
            tick();
        end
        in_valid = 1'b0;
        n_checks++;
        if (got != 20) begin
            n_fail++; $display("FAIL b2b_total: got %0d beats want 20", got);
        end
    endtask

    task automatic test_backpressure();
        int accepted;
        int drained;
        accepted = 0; drained = 0;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            drive_std(tag_t'(100 + accepted));
            in_valid = 1'b1;
            #1;
            if (in_ready) accepted++;
            tick();
        end
        n_checks++;
        if (accepted != DEPTH) begin
            n_fail++; $display("FAIL bp_accepted: got %0d want %0d", accepted, DEPTH);
        end
        n_checks++;
        if (in_ready !== 1'b0 || count !== CW'(DEPTH)) begin
            n_fail++; $display("FAIL bp_full: in_ready=%b count=%0d want 0/%0d", in_ready, count, DEPTH);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            #1;
            if (out_valid) begin
                n_checks++;
                if (out_tag !== tag_t'(100 + drained)) begin
                    n_fail++; $display("FAIL bp_drain_order: got %0d want %0d", out_tag, 100 + drained);
                end
                drained++;
            end
            tick();
        end
        n_checks++;
        if (drained != DEPTH) begin
            n_fail++; $display("FAIL bp_drained: got %0d want %0d", drained, DEPTH);
        end
    endtask

    task automatic test_flush();
        int  wait_cyc;
        logic seen;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_std(tag_t'(200 + i));
            in_valid = 1'b1;
            tick();
        end
        drive_std(16'd299);
        flush = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL flush_in_ready: got %b want 0", in_ready);
        end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_checks++;
        if (count !== '0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_clear: count=%0d out_valid=%b want 0/0", count, out_valid);
        end
        out_ready = 1'b1;
        seen = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        n_checks++;
        if (seen) begin
            n_fail++; $display("FAIL flush_stale: stale beat observed, want none");
        end
        drive_std(16'd210);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_cyc = 0;
        while (!out_valid && wait_cyc < 20) begin
            tick();
            wait_cyc++;
        end
        n_checks++;
        if (out_valid !== 1'b1 || out_tag !== 16'd210 || v0v1 !== STD_D01) begin
            n_fail++;
            $display("FAIL flush_after: out_valid=%b tag=%0d v0v1=%h want 1/210/%h",
                     out_valid, out_tag, v0v1, STD_D01);
        end
        tick();
    endtask

    task automatic test_reset_midflight();
        logic seen;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_std(tag_t'(300 + i));
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b0;
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || count !== '0) begin
            n_fail++; $display("FAIL midrst_clear: out_valid=%b count=%0d want 0/0", out_valid, count);
        end
        rst = 1'b1;
        seen = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        n_checks++;
        if (seen || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL midrst_stale: seen=%b in_ready=%b want 0/1", seen, in_ready);
        end
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t e;
        exp_t nb;
        exp_t held;
        logic prev_stall;
        int   sent;
        int   got;
        int   a0, a1, a2, ao;
        prev_stall = 1'b0; sent = 0; got = 0;
        held = '0;
        for (int cyc = 0; cyc < 20000 && got < N_RND; cyc++) begin
            if (prev_stall) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_tag !== held.tag || v0v1 !== held.d01 ||
                    v0v2 !== held.d02 || tvec !== held.dt) begin
                    n_fail++;
                    $display("FAIL rnd_stall_hold: valid=%b tag=%0d want tag %0d held",
                             out_valid, out_tag, held.tag);
                end
            end
            for (int i = 0; i < 3; i++) begin
                a0 = int'($urandom_range(2000)) - 1000;
                a1 = int'($urandom_range(2000)) - 1000;
                a2 = int'($urandom_range(2000)) - 1000;
                ao = int'($urandom_range(2000)) - 1000;
                v0[i*32 +: 32]     = int2fp(a0);
                v1[i*32 +: 32]     = int2fp(a1);
                v2[i*32 +: 32]     = int2fp(a2);
                orig[i*32 +: 32]   = int2fp(ao);
                nb.d01[i*32 +: 32] = int2fp(a1 - a0);
                nb.d02[i*32 +: 32] = int2fp(a2 - a0);
                nb.dt[i*32 +: 32]  = int2fp(ao - a0);
            end
            in_tag    = tag_t'(sent ^ 16'h5A00);
            nb.tag    = in_tag;
            in_valid  = (sent < N_RND) && ($urandom_range(99) < 60);
            out_ready = ($urandom_range(99) < 70);
            #1;
            if (out_valid && out_ready) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL rnd_extra: unexpected beat tag %0d", out_tag);
                end else begin
                    e = q.pop_front();
                    if (out_tag !== e.tag || v0v1 !== e.d01 || v0v2 !== e.d02 || tvec !== e.dt) begin
                        n_fail++;
                        $display("FAIL rnd_data: tag %h v0v1 %h v0v2 %h tvec %h want tag %h v0v1 %h v0v2 %h tvec %h",
                                 out_tag, v0v1, v0v2, tvec, e.tag, e.d01, e.d02, e.dt);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back(nb);
                sent++;
            end
            prev_stall = out_valid && !out_ready;
            held       = {v0v1, v0v2, tvec, out_tag};
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (got != N_RND || sent != N_RND || q.size() != 0) begin
            n_fail++;
            $display("FAIL rnd_count: sent %0d got %0d left %0d want %0d/%0d/0",
                     sent, got, q.size(), N_RND, N_RND);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/preprocess_v3.md
PREPROCESS_V3 -- requirements
Module: preprocess_v3

Interface
REQ-001 Parameter LANES, default 3, float components per vector.
REQ-002 Parameter FW, default 32, float width (IEEE-754 single).
REQ-003 Parameter ADD_LAT, default 3, Float_Add pipeline latency in cycles.
REQ-004 Parameter TAG_W, default 16, width of the triangle tag carried alongside the data.
REQ-005 Parameter DEPTH, default 8, output FIFO entries, at least ADD_LAT+1.
REQ-006 clk  input  1  the single clock.
REQ-007 rst  input  1  reset, synchronous and active-low.
REQ-008 flush  input  1  discards in-flight and queued results.
REQ-009 in_valid  input  1  input beat valid.
REQ-010 in_ready  output  1  block accepts a beat this cycle.
REQ-011 v0, v1, v2, orig  input  LANES*FW each  vertices and ray origin; lane i occupies bits [i*FW +: FW].
REQ-012 in_tag  input  TAG_W  triangle id.
REQ-013 out_valid  output  1  result beat valid.
REQ-014 out_ready  input  1  consumer accepts the result beat.
REQ-015 v0v1, v0v2, tvec  output  LANES*FW each  results v1-v0, v2-v0 and orig-v0.
REQ-016 out_tag  output  TAG_W  tag of the beat on the output.
REQ-017 count  output  $clog2(DEPTH+1)  entries in flight plus entries queued.

Function
REQ-018 A beat is accepted when in_valid and in_ready are both high in the same cycle.
REQ-019 Datapath: 3*LANES Float_Add instances with opSel=0 (subtract) and en=1. Operand a is v1, v2 or orig; operand b is v0.
REQ-020 A valid bit and the tag advance through an ADD_LAT-deep shift register that runs in lockstep with the adders.
REQ-021 When the valid bit exits the shift register, the adder outputs and the tag are written into the output FIFO in the same cycle.
REQ-022 in_ready = (count < DEPTH) && !flush. Credit scheme: count increments on accept and decrements on out_valid && out_ready. With both in one cycle, count is unchanged.
REQ-023 The FIFO can never overflow, so results are never dropped and en stays at 1.
REQ-024 Minimum latency from an accept to out_valid is ADD_LAT+1 cycles, assuming an empty FIFO and out_ready high.
REQ-025 Throughput is one beat per cycle under continuous in_valid and out_ready.
REQ-026 out_valid is high exactly when the FIFO is non-empty.
REQ-027 The output data and out_tag hold stable while out_valid && !out_ready.
REQ-028 Results leave in strict accept order.
REQ-029 The FIFO read and write pointers wrap modulo DEPTH.
REQ-030 When full, in_ready is 0. When empty, out_valid is 0.
REQ-031 A simultaneous FIFO write and read with the FIFO full is legal only if the write is credited, which the count guarantees.
REQ-032 flush clears all pipeline valid bits, the FIFO pointers and count in the next cycle. Nothing accepted before the flush appears at the output afterwards.
REQ-033 A beat offered in the flush cycle is not accepted, because in_ready is 0.

Reset
REQ-034 When rst=0 at a clk edge: out_valid=0, count=0, FIFO pointers=0, and all shift-register valid bits cleared.
REQ-035 After that reset, in_ready=1.
REQ-036 Data and tag registers are not reset. Their contents are don't-care while their valid bit is 0.
REQ-037 Float_Add areset is tied to 0; the adders' internal state is masked by the valid tracking.
REQ-038 Reset mid-operation behaves identically to flush, plus the reset output values of REQ-034.

Structure
REQ-039 Shared package pp_pkg holds the vec_t typedef (LANES*FW), the tag_t typedef, and default constants ADD_LAT_DEF=3 and DEPTH_DEF=8.
REQ-040 One sub-module, pp_fifo, implements the parametrised synchronous FIFO (width 3*LANES*FW+TAG_W, DEPTH entries).

Verification
REQ-041 Single beat with v0=(1,2,3), v1=(4,6,8), v2=(1,2,4), orig=(0,0,0), tag=0x0005, out_ready=1. Required at cycle ADD_LAT+1:
- v0v1=(0x40400000, 0x40800000, 0x40A00000)
- v0v2=(0, 0, 0x3F800000)
- tvec=(0xBF800000, 0xC0000000, 0xC0400000)
- out_tag=0x0005
REQ-042 Twenty back-to-back beats with tags 0..19 and out_ready=1. Required: one output per cycle, tags in order 0..19, count never above ADD_LAT+1.
REQ-043 Hold out_ready=0 with in_valid=1. Required: exactly DEPTH beats accepted, in_ready falls with count=DEPTH, then releasing out_ready drains all DEPTH results in order.
REQ-044 Accept 5 beats, then assert flush for one cycle. Required: count=0 next cycle and no output for the 5 flushed tags; a beat accepted afterwards emerges normally.
REQ-045 Drive rst=0 with 3 beats in flight. Required: out_valid=0 and count=0 after the edge, and no stale beat emerges after rst=1.
REQ-046 Random valid/ready stalls over 1000 beats, checked against a reference float-subtract model. Required: every result and tag matches, none is lost or duplicated, and outputs stay stable under stall.
